// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous memory between the fetch stage (IF) and
//   the memory stage (D). Only one access is granted per cycle. Stores get byte
//   enables and replicated write data. Load results are sign- or zero-extended
//   according to data_size_e.
//
// Ports
//   clk, rst_n                          clock, asynchronous active-low reset
//   if_req/if_addr                      fetch request, byte address
//   if_gnt/if_err/if_rvalid/if_rdata    fetch accept, reject, data valid, word
//   d_req/d_we/d_size/d_addr/d_wdata    data request, store flag, size, address, data
//   d_gnt/d_err/d_rvalid/d_rdata        data accept, reject, load valid, result
//   mem_en/mem_we/mem_be/mem_addr/
//   mem_wdata/mem_rdata                 memory macro port (read data arrives 1 cycle later)

package constants;
  localparam int ADDR_WIDTH = 9;

  typedef enum logic [2:0] {
    UNDEF  = 3'd0,
    BYTE_S = 3'd1,
    BYTE_U = 3'd2,
    HALF_S = 3'd3,
    HALF_U = 3'd4,
    WORD   = 3'd5
  } data_size_e;
endpackage

module mem_port_arbiter #(
  parameter int ADDR_WIDTH = constants::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_gnt,
  output logic                  if_err,
  output logic                  if_rvalid,
  output logic [31:0]           if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [2:0]            d_size,
  input  logic [31:0]           d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_gnt,
  output logic                  d_err,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);
  import constants::*;

  // Handshake: a requester raises req and holds req and its attributes stable
  // until it sees gnt. gnt is combinational in the same cycle. gnt together
  // with err means the request was accepted but rejected. A granted legal read
  // returns rvalid/rdata exactly one cycle later. Stores and rejected requests
  // return nothing.

  typedef enum logic [1:0] {NONE, IF_RESP, D_RESP} resp_e;

  resp_e       resp_q;
  logic [1:0]  d_streak_q;
  logic [1:0]  off_q;
  logic [2:0]  size_q;

  logic        if_ok;
  logic        d_ok;
  logic        d_size_ok;
  logic        d_align_ok;
  logic        d_range_ok;
  logic        d_wins;
  logic        if_wins;
  logic [31:0] lane;
  logic [31:0] d_ext;

  // Legality checks
  assign if_ok      = (if_addr[1:0] == 2'b00) &&
                      ((if_addr >> (ADDR_WIDTH + 2)) == 32'd0);
  assign d_range_ok = ((d_addr >> (ADDR_WIDTH + 2)) == 32'd0);

  always_comb begin
    d_size_ok  = 1'b1;
    d_align_ok = 1'b1;
    case (d_size)
      BYTE_S, BYTE_U: d_align_ok = 1'b1;
      HALF_S, HALF_U: d_align_ok = ~d_addr[0];
      WORD:           d_align_ok = (d_addr[1:0] == 2'b00);
      default:        d_size_ok  = 1'b0;
    endcase
  end

  assign d_ok = d_size_ok && d_align_ok && d_range_ok;

  // D has priority. After two consecutive D wins while IF was waiting, IF
  // gets the slot so that fetch cannot starve.
  assign d_wins  = d_req && !(if_req && (d_streak_q == 2'd2));
  assign if_wins = if_req && !d_wins;

  // Grant and memory drive. Everything is held at zero during reset.
  always_comb begin
    if_gnt    = 1'b0;
    if_err    = 1'b0;
    d_gnt     = 1'b0;
    d_err     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (rst_n) begin
      if (d_wins) begin
        d_gnt = 1'b1;
        d_err = ~d_ok;
        if (d_ok) begin
          mem_en   = 1'b1;
          mem_addr = d_addr[ADDR_WIDTH+1:2];
          if (d_we) begin
            mem_we = 1'b1;
            case (d_size)
              BYTE_S, BYTE_U: begin
                mem_be    = 4'b0001 << d_addr[1:0];
                mem_wdata = {4{d_wdata[7:0]}};
              end
              HALF_S, HALF_U: begin
                mem_be    = 4'b0011 << d_addr[1:0];
                mem_wdata = {2{d_wdata[15:0]}};
              end
              default: begin
                mem_be    = 4'hF;
                mem_wdata = d_wdata;
              end
            endcase
          end else begin
            mem_be = 4'hF;
          end
        end
      end else if (if_wins) begin
        if_gnt = 1'b1;
        if_err = ~if_ok;
        if (if_ok) begin
          mem_en   = 1'b1;
          mem_be   = 4'hF;
          mem_addr = if_addr[ADDR_WIDTH+1:2];
        end
      end
    end
  end

  // Response owner and starvation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q     <= NONE;
      d_streak_q <= 2'd0;
      off_q      <= 2'd0;
      size_q     <= 3'd0;
    end else begin
      if (d_wins && d_ok && !d_we) begin
        resp_q <= D_RESP;
        off_q  <= d_addr[1:0];
        size_q <= d_size;
      end else if (if_wins && if_ok) begin
        resp_q <= IF_RESP;
      end else begin
        resp_q <= NONE;
      end

      if (!if_req || if_wins) begin
        d_streak_q <= 2'd0;
      end else if (d_wins && (d_streak_q != 2'd2)) begin
        d_streak_q <= d_streak_q + 2'd1;
      end
    end
  end

  // Response formatting: move the addressed lane down to bit 0, then extend it
  assign lane = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    d_ext = lane;
    case (size_q)
      BYTE_S:  d_ext = {{24{lane[7]}}, lane[7:0]};
      BYTE_U:  d_ext = {24'h0, lane[7:0]};
      HALF_S:  d_ext = {{16{lane[15]}}, lane[15:0]};
      HALF_U:  d_ext = {16'h0, lane[15:0]};
      default: d_ext = lane;
    endcase
  end

  assign if_rvalid = (resp_q == IF_RESP);
  assign d_rvalid  = (resp_q == D_RESP);
  assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
  assign d_rdata   = d_rvalid  ? d_ext     : 32'h0;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the processor's single-port synchronous instruction/data memory between the fetch stage (IF) and the memory stage (D). It also formats each access: byte-lane enables and write-data replication for stores, and sign/zero extension for loads according to `data_size_e`. It sits between the pipeline and the memory macro and grants one access per cycle.

## Interface
Parameters:
- `ADDR_WIDTH`, default `constants::ADDR_WIDTH` (9). Memory word-address width; memory holds 2^ADDR_WIDTH 32-bit words.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: clock.
  - `rst_n` in 1: asynchronous active-low reset.
- Fetch requester:
  - `if_req` in 1: fetch request.
  - `if_addr` in 32: byte address.
  - `if_gnt` out 1: request accepted this cycle.
  - `if_err` out 1: request rejected (misaligned or out of range).
  - `if_rvalid` out 1: fetch data valid.
  - `if_rdata` out 32: fetched word.
- Data requester:
  - `d_req` in 1: data request.
  - `d_we` in 1: 1 = store, 0 = load.
  - `d_size` in 3: access size, `data_size_e`.
  - `d_addr` in 32: byte address.
  - `d_wdata` in 32: store data, right-aligned.
  - `d_gnt` out 1: request accepted this cycle.
  - `d_err` out 1: request rejected.
  - `d_rvalid` out 1: load data valid.
  - `d_rdata` out 32: extended load result.
- Memory side:
  - `mem_en` out 1: memory enable.
  - `mem_we` out 1: write enable.
  - `mem_be` out 4: byte enables.
  - `mem_addr` out ADDR_WIDTH: word address.
  - `mem_wdata` out 32: write data.
  - `mem_rdata` in 32: read data, valid the cycle after a read.

## Operation
**Request protocol**
- A requester holds `req` and its attributes stable until `gnt`.
- `gnt` is combinational in the access cycle.
- At most one grant per cycle. Back-to-back grants are allowed every cycle.

**Arbitration**
- D has priority over IF.
- Starvation guard uses a 2-bit `d_streak` counter:
  - Increments on each D grant while `if_req` is high and IF is not granted.
  - Clears on an IF grant or whenever `if_req` is low.
  - When `d_streak == 2` and both requests are pending, IF wins.

**Legality checks**
- IF request is illegal if `if_addr[1:0] != 0` or `if_addr[31:ADDR_WIDTH+2] != 0`.
- D request is illegal if any of the following holds:
  - `d_size` is `UNDEF` or any encoding above `WORD`.
  - HALF access with `d_addr[0] = 1`.
  - WORD access with `d_addr[1:0] != 0`.
  - Address out of range (same upper-bit rule as IF).
- An illegal winner gets `gnt = 1` and `err = 1` in the same cycle. There is no memory access (`mem_en = 0`) and no later `rvalid`. The arbitration slot is consumed.

**Memory drive on a legal grant**
- `mem_en = 1`.
- `mem_addr = addr[ADDR_WIDTH+1:2]`.

**Stores** (`mem_we = 1`)
- Byte enables:
  - BYTE: `mem_be = 4'b0001 << d_addr[1:0]`.
  - HALF: `mem_be = 4'b0011 << d_addr[1:0]`.
  - WORD: `mem_be = 4'hF`.
- Write data:
  - BYTE: `mem_wdata = {4{d_wdata[7:0]}}`.
  - HALF: `mem_wdata = {2{d_wdata[15:0]}}`.
  - WORD: `mem_wdata = d_wdata`.
- Stores produce no `d_rvalid`.

**Reads** (IF fetch, D load)
- `mem_we = 0`, `mem_be = 4'hF`.
- Response FSM register `resp_q` ∈ {`NONE`, `IF_RESP`, `D_RESP`} is loaded at the grant edge with the owner of the read. Store, error and idle cycles load `NONE`.
- The byte offset and `d_size` are captured alongside.

**Response formatting**
- `if_rdata = mem_rdata`.
- `d_rdata`: select the lane `mem_rdata >> (8*offset)`, then:
  - `BYTE_S`: sign-extend bit 7.
  - `BYTE_U`: zero-extend the byte.
  - `HALF_S`: sign-extend bit 15.
  - `HALF_U`: zero-extend the halfword.
  - `WORD`: unchanged.
- `if_rdata` and `d_rdata` are 0 when the corresponding `rvalid` is 0.

## Timing
- Grant cycle T: `gnt`/`err`, `mem_*` all combinational.
- Read data returns at T+1: `rvalid` = registered (`resp_q`), `rdata` combinational from `mem_rdata`. Read latency is 1 cycle.
- A new grant at T+1 is allowed concurrently with the response from T.
- Reset values:
  - `resp_q = NONE`, `d_streak = 0`.
  - All `gnt`, `err`, `rvalid`, `rdata`, `mem_en`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata` are 0. Outputs are forced 0 while `rst_n = 0`.
- Reset mid-operation: a pending response is dropped; no `rvalid` after release.
- When both requesters are idle, `mem_en = 0` and the `mem_*` buses are 0.

## Test plan
1. **Fetch only:** `if_req` with `if_addr = 0x10`; memory word 4 = `0x00500093`.
   - Required: `if_gnt` at T, `mem_addr = 4`, `if_rvalid` at T+1, `if_rdata = 0x00500093`.
2. **Simultaneous requests:** both requesters active for 4 cycles, D loads each cycle.
   - Required grant order D, D, IF, D. `d_streak` clears after the IF grant.
3. **Stores:**
   - SB `d_addr = 0x3`, `d_wdata = 0xAB` → `mem_be = 1000`, `mem_wdata = 0xABABABAB`.
   - SH `d_addr = 0x2`, `d_wdata = 0x1234` → `mem_be = 1100`, `mem_wdata = 0x12341234`.
4. **Loads from word `0x80FF7F01`:**
   - LB offset 2 → `0xFFFFFFFF`.
   - LBU offset 3 → `0x00000080`.
   - LH offset 2 → `0xFFFF80FF`.
   - LHU offset 0 → `0x00007F01`.
   - LW → `0x80FF7F01`.
5. **Errors:**
   - LW `d_addr = 0x6` → `d_gnt = d_err = 1`, `mem_en = 0`, no `d_rvalid`.
   - `d_size = UNDEF` → same response.
   - `if_addr = 0x800` with `ADDR_WIDTH = 9` → `if_err = 1`.
6. **Reset during read:** assert `rst_n = 0` in cycle T+1 of a load.
   - Required: `d_rvalid` stays 0, all outputs are 0, and the first grant after release behaves normally.
